// File: rtl/wb_dma_copy_pkg.sv
// Shared types and constants for the Wishbone block-copy master.
// Reused by the top FSM and its ack-timeout helper.
package wb_dma_copy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FINISH = 2'd3
   } dma_state_e;

   localparam logic [3:0] WB_SEL_ALL = 4'hF;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] WORD_STEP = 32'd4;

endpackage

// File: rtl/wb_dma_copy_timeout.sv
// Per-access ack watchdog; expired flags the cycle whose
// increment would reach the limit, so the abort lands on that edge.
module wb_ack_timeout #(
   parameter int timeout = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   assign expired = en && !clear && (cnt_q == 16'(timeout - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_dma_copy.sv
// Wishbone block-copy master: one single read then one single
// write per word, with a per-access ack timeout abort.
module wb_dma_copy
   import wb_dma_copy_pkg::*;
#(
   parameter int cnt_width = 16,
   parameter int timeout   = 1023
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 start,
   input  logic [31:0]          src_adr,
   input  logic [31:0]          dst_adr,
   input  logic [cnt_width-1:0] count,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [31:0]          wb_adr_o,
   output logic [3:0]           wb_sel_o,
   output logic [31:0]          wb_dat_o,
   input  logic [31:0]          wb_dat_i,
   input  logic                 wb_ack_i
);

   dma_state_e state_q, state_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [cnt_width-1:0] rem_q, rem_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic err_q, err_d;
   logic cyc_q, cyc_d;
   logic we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic to_clear, to_en, to_expired;
   logic in_access;

   assign in_access = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign to_en     = in_access && !wb_ack_i;

   wb_ack_timeout #(
      .timeout(timeout)
   ) u_timeout (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .clear  (to_clear),
      .en     (to_en),
      .expired(to_expired)
   );

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rem_d    = rem_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      to_clear = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d    = src_adr & WORD_MASK;
               dst_d    = dst_adr & WORD_MASK;
               rem_d    = count;
               err_d    = 1'b0;
               busy_d   = 1'b1;
               to_clear = 1'b1;
               if (count == '0) begin
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_READ;
                  cyc_d   = 1'b1;
                  we_d    = 1'b0;
                  adr_d   = src_adr & WORD_MASK;
               end
            end
         end
         ST_READ: begin
            if (wb_ack_i) begin
               dat_d    = wb_dat_i;
               src_d    = src_q + WORD_STEP;
               we_d     = 1'b1;
               adr_d    = dst_q;
               to_clear = 1'b1;
               state_d  = ST_WRITE;
            end else if (to_expired) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end
         end
         ST_WRITE: begin
            if (wb_ack_i) begin
               dst_d    = dst_q + WORD_STEP;
               rem_d    = rem_q - 1'b1;
               we_d     = 1'b0;
               to_clear = 1'b1;
               if (rem_q == cnt_width'(1)) begin
                  cyc_d   = 1'b0;
                  state_d = ST_FINISH;
               end else begin
                  adr_d   = src_q;
                  state_d = ST_READ;
               end
            end else if (to_expired) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_sel_o = WB_SEL_ALL;
   assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Directed bench for wb_dma_copy against a 2-cycle-per-access
// BRAM-style slave that toggles ack while stb is held.
module tb_wb_dma_copy;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_adr = '0;
   logic [31:0] dst_adr = '0;
   logic [15:0] count = '0;
   logic        busy, done, err;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;

   logic [31:0] mem [0:255];
   logic        slave_en = 1'b1;
   logic        ack_q;

   int checks = 0;
   int errors = 0;
   int cycles, acc_n, cyc_seen, busy_n, proto_bad;
   bit we_seen, done_seen;
   logic [31:0] rd_log [$];

   wb_dma_copy #(
      .cnt_width(16),
      .timeout  (8)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .start   (start),
      .src_adr (src_adr),
      .dst_adr (dst_adr),
      .count   (count),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o),
      .wb_we_o (wb_we_o),
      .wb_adr_o(wb_adr_o),
      .wb_sel_o(wb_sel_o),
      .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) ack_q <= 1'b0;
      else ack_q <= wb_cyc_o & wb_stb_o & ~ack_q & slave_en;
   end

   assign wb_ack_i = ack_q;
   assign wb_dat_i = mem[wb_adr_o[9:2]];

   task automatic clear_log();
      cycles = 0; acc_n = 0; cyc_seen = 0; busy_n = 0;
      proto_bad = 0; we_seen = 0; done_seen = 0;
      rd_log.delete();
   endtask

   // Slave write and bus observation for the current cycle, then one clock.
   task automatic step();
      if (wb_cyc_o && wb_ack_i) begin
         acc_n++;
         if (wb_we_o) mem[wb_adr_o[9:2]] = wb_dat_o;
         else rd_log.push_back(wb_adr_o);
      end
      if (wb_cyc_o) cyc_seen++;
      if (wb_we_o) we_seen = 1;
      if (busy) busy_n++;
      if (done) done_seen = 1;
      if (wb_sel_o !== 4'hF || wb_stb_o !== wb_cyc_o) proto_bad++;
      @(posedge sys_clk);
      #1;
      cycles++;
   endtask

   task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n);
      clear_log();
      @(negedge sys_clk);
      src_adr = s; dst_adr = d; count = n; start = 1'b1;
      step();
      start = 1'b0;
      while (!done && cycles < 200) step();
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b want 000000",
                  {busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o});
      end
      checks++;
      if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus adr %h dat %h want 0", wb_adr_o, wb_dat_o);
      end
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic test_copy();
      mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
      mem[2] = 32'h3333_3333; mem[3] = 32'h4444_4444;
      for (int i = 0; i < 4; i++) mem[8'h40 + i] = 32'h0;
      run_job(32'h000, 32'h100, 16'd4);
      checks++;
      if (!done || cycles != 18) begin
         errors++;
         $display("FAIL copy_latency got %0d done %b want 18", cycles, done);
      end
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL copy_flags err %b busy %b want 0 0", err, busy);
      end
      checks++;
      if (acc_n != 8) begin
         errors++;
         $display("FAIL copy_accesses got %0d want 8", acc_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[8'h40 + i] !== mem[i]) begin
            errors++;
            $display("FAIL copy_data[%0d] got %h want %h", i,
                     mem[8'h40 + i], mem[i]);
         end
      end
      checks++;
      if (proto_bad != 0) begin
         errors++;
         $display("FAIL copy_sel_stb got %0d bad cycles want 0", proto_bad);
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL copy_done_pulse got %b want 0", done);
      end
   endtask

   task automatic test_zero_length();
      run_job(32'h040, 32'h140, 16'd0);
      checks++;
      if (!done || cycles != 2) begin
         errors++;
         $display("FAIL zero_latency got %0d done %b want 2", cycles, done);
      end
      checks++;
      if (cyc_seen != 0 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL zero_cyc got %0d cycles want 0", cyc_seen);
      end
      checks++;
      if (busy_n != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_busy got %0d cycles want 1", busy_n);
      end
   endtask

   task automatic test_timeout();
      slave_en = 1'b0;
      run_job(32'h020, 32'h120, 16'd2);
      checks++;
      if (cyc_seen != 8) begin
         errors++;
         $display("FAIL timeout_wait got %0d want 8", cyc_seen);
      end
      checks++;
      if (!done || err !== 1'b1 || cycles != 10) begin
         errors++;
         $display("FAIL timeout_done done %b err %b at %0d want 1 1 at 10",
                  done, err, cycles);
      end
      checks++;
      if (we_seen || acc_n != 0) begin
         errors++;
         $display("FAIL timeout_nowrite we %b acc %0d want 0 0",
                  we_seen, acc_n);
      end
      step();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err_hold got %b want 1", err);
      end
      slave_en = 1'b1;
   endtask

   task automatic test_wrap();
      mem[8'hFF] = 32'hAAAA_5555;
      mem[8'h80] = 32'h0; mem[8'h81] = 32'h0;
      run_job(32'hFFFF_FFFE, 32'h200, 16'd2);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_err_clear got %b want 0", err);
      end
      checks++;
      if (rd_log.size() != 2 || rd_log[0] !== 32'hFFFF_FFFC ||
          rd_log[1] !== 32'h0) begin
         errors++;
         $display("FAIL wrap_adr n %0d want reads FFFFFFFC 00000000",
                  rd_log.size());
      end
      checks++;
      if (mem[8'h80] !== 32'hAAAA_5555 || mem[8'h81] !== 32'h1111_1111) begin
         errors++;
         $display("FAIL wrap_data got %h %h want aaaa5555 11111111",
                  mem[8'h80], mem[8'h81]);
      end
      checks++;
      if (proto_bad != 0) begin
         errors++;
         $display("FAIL wrap_sel got %0d bad cycles want 0", proto_bad);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      mem[8'h70] = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) mem[8'h60 + i] = 32'h0;
      clear_log();
      @(negedge sys_clk);
      src_adr = 32'h000; dst_adr = 32'h180; count = 16'd4; start = 1'b1;
      step();
      start = 1'b0;
      while (!done && cycles < 200) begin
         if (cycles == 5) begin
            src_adr = 32'h3C0; dst_adr = 32'h1C0; count = 16'd1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      checks++;
      if (!done || cycles != 18) begin
         errors++;
         $display("FAIL busy_start_latency got %0d want 18", cycles);
      end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (mem[8'h60 + i] !== mem[i]) bad++;
         if (i < rd_log.size() && rd_log[i] !== 32'(i * 4)) bad++;
      end
      if (rd_log.size() != 4) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL busy_start_data got %0d bad words want 0", bad);
      end
      checks++;
      if (mem[8'h70] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL busy_start_ignored got %h want deadbeef", mem[8'h70]);
      end
   endtask

   task automatic test_reset_mid_write();
      int writes;
      bit prev_we;
      writes = 0; prev_we = 0;
      clear_log();
      @(negedge sys_clk);
      src_adr = 32'h000; dst_adr = 32'h240; count = 16'd4; start = 1'b1;
      step();
      start = 1'b0;
      while (writes < 2 && cycles < 100) begin
         if (wb_cyc_o && wb_we_o && !prev_we) writes++;
         prev_we = wb_we_o;
         if (writes < 2) step();
      end
      checks++;
      if (writes != 2) begin
         errors++;
         $display("FAIL rst_reach_write got %0d writes want 2", writes);
      end
      sys_rst = 1'b1;
      #1;
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_release cyc %b stb %b busy %b want 0 0 0",
                  wb_cyc_o, wb_stb_o, busy);
      end
      done_seen = 0;
      repeat (3) step();
      @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (3) step();
      checks++;
      if (done_seen) begin
         errors++;
         $display("FAIL rst_no_done got done pulse want none");
      end
      mem[8'hA0] = 32'h0; mem[8'hA1] = 32'h0;
      run_job(32'h008, 32'h280, 16'd2);
      checks++;
      if (!done || cycles != 10 || err !== 1'b0) begin
         errors++;
         $display("FAIL rst_fresh_job at %0d err %b want 10 0", cycles, err);
      end
      checks++;
      if (mem[8'hA0] !== 32'h3333_3333 || mem[8'hA1] !== 32'h4444_4444) begin
         errors++;
         $display("FAIL rst_fresh_data got %h %h want 33333333 44444444",
                  mem[8'hA0], mem[8'hA1]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      test_reset();
      test_copy();
      test_zero_length();
      test_timeout();
      test_wrap();
      test_back_to_back();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
